// File: rtl/ds1302_time_ctrl.sv
// DS1302 transaction sequencer: WP clear after reset, periodic sec/min/hour snapshot reads, on-demand time writes.
// One byte transaction at a time, waits on ack without timeout; `define DS1302_DATE_EN adds date/month/year.
module ds1302_time_ctrl #(
    parameter int unsigned READ_PERIOD = 25_000_000,
    parameter bit          INIT_WP_CLR = 1'b1
) (
    input  logic       ds1302_clk,
    input  logic       ds1302_rst,
    input  logic       set_req,
    input  logic [7:0] set_sec,
    input  logic [7:0] set_min,
    input  logic [7:0] set_hour,
    input  logic [7:0] set_date,
    input  logic [7:0] set_mon,
    input  logic [7:0] set_year,
    output logic [7:0] time_sec,
    output logic [7:0] time_min,
    output logic [7:0] time_hour,
    output logic [7:0] time_date,
    output logic [7:0] time_mon,
    output logic [7:0] time_year,
    output logic       time_valid,
    output logic       set_done,
    output logic       busy,
    output logic [7:0] ds1302_write_addr,
    output logic [7:0] ds1302_write_data,
    output logic       ds1302_write_en,
    input  logic       ds1302_write_ack,
    output logic [7:0] ds1302_read_addr,
    input  logic [7:0] ds1302_read_data,
    output logic       ds1302_read_en,
    input  logic       ds1302_read_ack
);
    localparam int unsigned TW = (READ_PERIOD > 2) ? $clog2(READ_PERIOD) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(READ_PERIOD - 2);

    typedef enum logic [3:0] {
        INIT, RD_SEC, RD_MIN, RD_HOUR,
`ifdef DS1302_DATE_EN
        RD_DATE, RD_MON, RD_YEAR,
`endif
        UPDATE, IDLE, WR_WP, WR_SEC, WR_MIN, WR_HOUR
`ifdef DS1302_DATE_EN
        , WR_DATE, WR_MON, WR_YEAR
`endif
    } state_t;

    state_t          state_q, next_d;
    logic [TW-1:0]   timer_q;
    logic            pend_q, busy_q, tv_q, done_q;
    logic            rd_en_q, wr_en_q;
    logic [7:0]      rd_addr_q, wr_addr_q, wr_data_q;
    logic [6:0]      bsec_q, bhour_q, ssec_q, tsec_q;
    logic [7:0]      bmin_q, smin_q, shour_q, tmin_q, thour_q;
    logic [7:0]      addr_d, data_d;
    logic            is_rd_d, last_wr_d;
    logic            unused_set_bits;

`ifdef DS1302_DATE_EN
    logic [7:0] bdate_q, bmon_q, byear_q, sdate_q, smon_q, syear_q, tdate_q, tmon_q, tyear_q;
    assign time_date = tdate_q;
    assign time_mon  = tmon_q;
    assign time_year = tyear_q;
    assign unused_set_bits = ^{set_sec[7], set_hour[7]};
`else
    assign time_date = 8'h00;
    assign time_mon  = 8'h00;
    assign time_year = 8'h00;
    assign unused_set_bits = ^{set_sec[7], set_hour[7], set_date, set_mon, set_year};
`endif

    assign time_sec          = {1'b0, tsec_q};
    assign time_min          = tmin_q;
    assign time_hour         = thour_q;
    assign time_valid        = tv_q;
    assign set_done          = done_q;
    assign busy              = busy_q;
    assign ds1302_write_addr = wr_addr_q;
    assign ds1302_write_data = wr_data_q;
    assign ds1302_write_en   = wr_en_q;
    assign ds1302_read_addr  = rd_addr_q;
    assign ds1302_read_en    = rd_en_q;

    // Per-state register address, write byte and successor.
    always_comb begin
        addr_d    = 8'h00;
        data_d    = 8'h00;
        next_d    = state_q;
        is_rd_d   = 1'b0;
        last_wr_d = 1'b0;
        case (state_q)
            INIT:    begin addr_d = 8'h8E; next_d = RD_SEC; end
            RD_SEC:  begin addr_d = 8'h81; is_rd_d = 1'b1; next_d = RD_MIN; end
            RD_MIN:  begin addr_d = 8'h83; is_rd_d = 1'b1; next_d = RD_HOUR; end
`ifdef DS1302_DATE_EN
            RD_HOUR: begin addr_d = 8'h85; is_rd_d = 1'b1; next_d = RD_DATE; end
            RD_DATE: begin addr_d = 8'h87; is_rd_d = 1'b1; next_d = RD_MON; end
            RD_MON:  begin addr_d = 8'h89; is_rd_d = 1'b1; next_d = RD_YEAR; end
            RD_YEAR: begin addr_d = 8'h8D; is_rd_d = 1'b1; next_d = UPDATE; end
            WR_HOUR: begin addr_d = 8'h84; data_d = {1'b0, bhour_q}; next_d = WR_DATE; end
            WR_DATE: begin addr_d = 8'h86; data_d = bdate_q; next_d = WR_MON; end
            WR_MON:  begin addr_d = 8'h88; data_d = bmon_q; next_d = WR_YEAR; end
            WR_YEAR: begin addr_d = 8'h8C; data_d = byear_q; next_d = RD_SEC; last_wr_d = 1'b1; end
`else
            RD_HOUR: begin addr_d = 8'h85; is_rd_d = 1'b1; next_d = UPDATE; end
            WR_HOUR: begin addr_d = 8'h84; data_d = {1'b0, bhour_q}; next_d = RD_SEC; last_wr_d = 1'b1; end
`endif
            WR_WP:   begin addr_d = 8'h8E; next_d = WR_SEC; end
            WR_SEC:  begin addr_d = 8'h80; data_d = {1'b0, bsec_q}; next_d = WR_MIN; end
            WR_MIN:  begin addr_d = 8'h82; data_d = bmin_q; next_d = WR_HOUR; end
            default: ;
        endcase
    end

    always_ff @(posedge ds1302_clk or posedge ds1302_rst) begin
        if (ds1302_rst) begin
            if (INIT_WP_CLR) state_q <= INIT;
            else             state_q <= RD_SEC;
            timer_q   <= '0;
            pend_q    <= 1'b0;
            busy_q    <= 1'b0;
            tv_q      <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_addr_q <= 8'h00;
            wr_addr_q <= 8'h00;
            wr_data_q <= 8'h00;
            bsec_q    <= '0;
            bmin_q    <= '0;
            bhour_q   <= '0;
            ssec_q    <= '0;
            smin_q    <= '0;
            shour_q   <= '0;
            tsec_q    <= '0;
            tmin_q    <= '0;
            thour_q   <= '0;
`ifdef DS1302_DATE_EN
            bdate_q <= '0; bmon_q <= '0; byear_q <= '0;
            sdate_q <= '0; smon_q <= '0; syear_q <= '0;
            tdate_q <= '0; tmon_q <= '0; tyear_q <= '0;
`endif
        end else begin
            tv_q    <= 1'b0;
            done_q  <= 1'b0;
            timer_q <= '0;
            if (set_req) begin
                bsec_q  <= set_sec[6:0];
                bmin_q  <= set_min;
                bhour_q <= set_hour[6:0];
`ifdef DS1302_DATE_EN
                bdate_q <= set_date;
                bmon_q  <= set_mon;
                byear_q <= set_year;
`endif
            end
            // A request seen in IDLE is consumed directly by the set frame it launches.
            if (state_q == IDLE && (pend_q || set_req)) pend_q <= 1'b0;
            else if (set_req)                           pend_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (pend_q || set_req) begin
                        state_q <= WR_WP;
                        busy_q  <= 1'b1;
                    end else if (timer_q == T_LAST) begin
                        state_q <= RD_SEC;
                        busy_q  <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                UPDATE: begin
                    tsec_q  <= ssec_q;
                    tmin_q  <= smin_q;
                    thour_q <= shour_q;
`ifdef DS1302_DATE_EN
                    tdate_q <= sdate_q;
                    tmon_q  <= smon_q;
                    tyear_q <= syear_q;
`endif
                    tv_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q <= 1'b1;
                    if (is_rd_d) begin
                        if (!rd_en_q) begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= addr_d;
                        end else if (ds1302_read_ack) begin
                            rd_en_q <= 1'b0;
                            state_q <= next_d;
                            case (state_q)
                                RD_SEC:  ssec_q  <= ds1302_read_data[6:0];
                                RD_MIN:  smin_q  <= ds1302_read_data;
                                RD_HOUR: shour_q <= ds1302_read_data;
`ifdef DS1302_DATE_EN
                                RD_DATE: sdate_q <= ds1302_read_data;
                                RD_MON:  smon_q  <= ds1302_read_data;
                                RD_YEAR: syear_q <= ds1302_read_data;
`endif
                                default: ;
                            endcase
                        end
                    end else begin
                        if (!wr_en_q) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= addr_d;
                            wr_data_q <= data_d;
                        end else if (ds1302_write_ack) begin
                            wr_en_q <= 1'b0;
                            state_q <= next_d;
                            done_q  <= last_wr_d;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ds1302_time_ctrl.sv
// Scoreboard bench for ds1302_time_ctrl with a DS1302 converter model and a register-array chip model.
module tb_ds1302_time_ctrl;
    localparam int RP = 100;
`ifdef DS1302_DATE_EN
    localparam int NREG = 6;
`else
    localparam int NREG = 3;
`endif
    localparam logic [7:0] RD_LIST [6] = '{8'h81, 8'h83, 8'h85, 8'h87, 8'h89, 8'h8D};

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;

    logic       clk = 1'b0, rst = 1'b1, set_req = 1'b0;
    logic [7:0] set_sec = '0, set_min = '0, set_hour = '0, set_date = '0, set_mon = '0, set_year = '0;
    logic [7:0] time_sec, time_min, time_hour, time_date, time_mon, time_year;
    logic       time_valid, set_done, busy;
    logic [7:0] wr_addr, wr_data, rd_addr;
    logic [7:0] rd_data = '0;
    logic       wr_en, rd_en;
    logic       wr_ack = 1'b0, rd_ack = 1'b0;

    txn_t        exp_q[$];
    logic [47:0] snap_q[$];
    logic [7:0]  regs [8];
    int checks = 0, errors = 0, done_exp = 0, done_seen = 0;
    bit rand_lat = 1'b0;

    ds1302_time_ctrl #(.READ_PERIOD(RP), .INIT_WP_CLR(1'b1)) dut (
        .ds1302_clk(clk), .ds1302_rst(rst), .set_req(set_req),
        .set_sec(set_sec), .set_min(set_min), .set_hour(set_hour),
        .set_date(set_date), .set_mon(set_mon), .set_year(set_year),
        .time_sec(time_sec), .time_min(time_min), .time_hour(time_hour),
        .time_date(time_date), .time_mon(time_mon), .time_year(time_year),
        .time_valid(time_valid), .set_done(set_done), .busy(busy),
        .ds1302_write_addr(wr_addr), .ds1302_write_data(wr_data), .ds1302_write_en(wr_en),
        .ds1302_write_ack(wr_ack), .ds1302_read_addr(rd_addr), .ds1302_read_data(rd_data),
        .ds1302_read_en(rd_en), .ds1302_read_ack(rd_ack)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [47:0] snap_of(input logic [7:0] s, m, h, d, mo, y);
        if (NREG == 6) return {1'b0, s[6:0], m, h, d, mo, y};
        return {1'b0, s[6:0], m, h, 24'h0};
    endfunction

    function automatic logic [7:0] rbcd(input int maxv);
        int v;
        v = $urandom_range(0, maxv);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic push_read_frame();
        for (int i = 0; i < NREG; i++) exp_q.push_back({1'b0, RD_LIST[i], 8'h00});
        snap_q.push_back(snap_of(regs[0], regs[1], regs[2], regs[3], regs[4], regs[6]));
    endtask

    // A set frame: WP clear, the time bytes (CH and 12/24 bits forced 0), then a read-back frame.
    task automatic push_set_frame(input logic [7:0] s, m, h, d, mo, y);
        exp_q.push_back({1'b1, 8'h8E, 8'h00});
        exp_q.push_back({1'b1, 8'h80, 1'b0, s[6:0]});
        exp_q.push_back({1'b1, 8'h82, m});
        exp_q.push_back({1'b1, 8'h84, 1'b0, h[6:0]});
        if (NREG == 6) begin
            exp_q.push_back({1'b1, 8'h86, d});
            exp_q.push_back({1'b1, 8'h88, mo});
            exp_q.push_back({1'b1, 8'h8C, y});
        end
        for (int i = 0; i < NREG; i++) exp_q.push_back({1'b0, RD_LIST[i], 8'h00});
        snap_q.push_back(snap_of({1'b0, s[6:0]}, m, {1'b0, h[6:0]}, d, mo, y));
        done_exp++;
    endtask

    task automatic pulse_set(input logic [7:0] s, m, h, d, mo, y);
        set_sec = s; set_min = m; set_hour = h; set_date = d; set_mon = mo; set_year = y;
        set_req = 1'b1;
        @(negedge clk);
        set_req = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        bit got = 1'b0;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(negedge clk);
            got = time_valid;
        end
        if (!got) chk({name, "_timeout"}, 1, 0);
    endtask

    task automatic wait_rd(input logic [7:0] a);
        bit got = 1'b0;
        for (int k = 0; k < 1000 && !got; k++) begin
            @(negedge clk);
            got = rd_en && (rd_addr == a);
        end
        if (!got) chk("wait_rd_timeout", {56'h0, a}, 0);
    endtask

    task automatic check_gap();
        int gap = -1;
        for (int i = 1; i <= RP + 50 && gap < 0; i++) begin
            @(negedge clk);
            if (rd_en) gap = i;
        end
        chk("period_gap", gap, RP);
    endtask

    // Converter model: acks N cycles after en rises, reads/writes the chip register array.
    initial begin
        int cnt = 0, lat = 20;
        forever begin
            @(negedge clk);
            wr_ack = 1'b0;
            rd_ack = 1'b0;
            if (rst) cnt = 0;
            else if (rd_en || wr_en) begin
                if (cnt == 0) lat = rand_lat ? $urandom_range(1, 20) : 20;
                cnt++;
                if (cnt >= lat) begin
                    if (rd_en) begin rd_ack = 1'b1; rd_data = regs[rd_addr[3:1]]; end
                    else begin wr_ack = 1'b1; regs[wr_addr[3:1]] = wr_data; end
                    cnt = 0;
                end
            end else begin
                cnt = 0;
                if (rand_lat && $urandom_range(0, 15) == 0) begin
                    rd_ack = 1'b1; wr_ack = 1'b1; rd_data = 8'($urandom);
                end
            end
        end
    end

    // Monitor: transaction order/content, handshake hold, snapshots, set_done pulses.
    initial begin
        logic prd = 1'b0, pwr = 1'b0;
        txn_t held, e;
        forever begin
            @(negedge clk);
            if (rd_en || wr_en) chk("en_exclusive", {rd_en, wr_en} == 2'b11, 0);
            if ((rd_en && !prd) || (wr_en && !pwr)) begin
                held = rd_en ? {1'b0, rd_addr, 8'h00} : {1'b1, wr_addr, wr_data};
                if (exp_q.size() == 0) chk("unexpected_txn", held, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("txn", held, e);
                end
            end else if (rd_en) chk("rd_addr_hold", {1'b0, rd_addr, 8'h00}, held);
            else if (wr_en) chk("wr_hold", {1'b1, wr_addr, wr_data}, held);
            if (time_valid) begin
                if (snap_q.size() == 0) chk("unexpected_valid", 1, 0);
                else chk("snapshot", {time_sec, time_min, time_hour, time_date, time_mon, time_year},
                         snap_q.pop_front());
            end
            if (set_done) done_seen++;
            prd = rd_en;
            pwr = wr_en;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s, m, h, d, mo, y;
        regs = '{8'h30, 8'h45, 8'h12, 8'h01, 8'h01, 8'h00, 8'h24, 8'h80};
        repeat (3) @(negedge clk);
        chk("reset_outputs", {time_sec, time_min, time_hour, time_date, time_mon, time_year, time_valid,
            set_done, busy, wr_addr, wr_data, wr_en, rd_addr, rd_en}, 0);

        // WP clear then first snapshot 12:45:30
        exp_q.push_back({1'b1, 8'h8E, 8'h00});
        push_read_frame();
        rst = 1'b0;
        wait_valid("first_frame");
        chk("idle_busy", busy, 0);
        chk("wp_cleared", regs[7], 8'h00);

        // CH bit masked, read period measured from IDLE entry
        regs[0] = 8'hB0;
        push_read_frame();
        check_gap();
        wait_valid("ch_frame");

        // set during RD_MIN: frame completes, then set frame and read-back
        push_read_frame();
        wait_rd(8'h83);
        push_set_frame(8'h58, 8'h59, 8'h23, 8'h31, 8'h12, 8'h25);
        pulse_set(8'h58, 8'h59, 8'h23, 8'h31, 8'h12, 8'h25);
        wait_valid("set_a");
        wait_valid("set_b");
        chk("set_done_1", done_seen, done_exp);

        // two set pulses in one frame: one set frame with the last value
        push_read_frame();
        wait_rd(8'h81);
        push_set_frame(8'h00, 8'h00, 8'h10, 8'h15, 8'h06, 8'h30);
        pulse_set(8'h00, 8'h00, 8'h09, 8'h01, 8'h01, 8'h01);
        repeat (3) @(negedge clk);
        pulse_set(8'h00, 8'h00, 8'h10, 8'h15, 8'h06, 8'h30);
        wait_valid("dbl_a");
        wait_valid("dbl_b");
        chk("set_done_2", done_seen, done_exp);

        // reset 5 cycles into RD_HOUR
        push_read_frame();
        wait_rd(8'h85);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_en_drop", {rd_en, wr_en}, 0);
        chk("rst_time_clear", {time_sec, time_min, time_hour, time_date, time_mon, time_year}, 0);
        snap_q.delete();
        chk("rst_exp_drained", exp_q.size(), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold", {time_valid, rd_en, wr_en}, 0);
        end
        exp_q.push_back({1'b1, 8'h8E, 8'h00});
        push_read_frame();
        rst = 1'b0;
        wait_valid("post_reset");

`ifdef DS1302_DATE_EN
        push_set_frame(8'h08, 8'h30, 8'h07, 8'h31, 8'h12, 8'h25);
        pulse_set(8'h08, 8'h30, 8'h07, 8'h31, 8'h12, 8'h25);
        wait_valid("date_set");
        chk("set_done_date", done_seen, done_exp);
`endif

        // randomized: timer frames with random chip contents, or set requests at random IDLE offsets
        rand_lat = 1'b1;
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                regs[0] = rbcd(59) | 8'($urandom_range(0, 1) << 7);
                regs[1] = rbcd(59);
                regs[2] = rbcd(23);
                regs[3] = rbcd(28) + 8'h01;
                regs[4] = rbcd(9) + 8'h01;
                regs[6] = rbcd(99);
                push_read_frame();
                check_gap();
                wait_valid("rand_timer");
            end else begin
                s = rbcd(59) | 8'($urandom_range(0, 1) << 7);
                m = rbcd(59);
                h = rbcd(23) | 8'($urandom_range(0, 1) << 7);
                d = rbcd(28) + 8'h01;
                mo = rbcd(9) + 8'h01;
                y = rbcd(99);
                repeat ($urandom_range(0, 90)) @(negedge clk);
                push_set_frame(s, m, h, d, mo, y);
                pulse_set(s, m, h, d, mo, y);
                wait_valid("rand_set");
                chk("rand_set_done", done_seen, done_exp);
            end
        end

        repeat (20) @(negedge clk);
        chk("txn_queue_empty", exp_q.size(), 0);
        chk("snap_queue_empty", snap_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
